// File: rtl/uart_pkg.sv
// Shared constants for the UART hex command parser: ASCII codes, error codes
// and parser state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_UC_F  = 8'h46;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_F  = 8'h66;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHAR    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOT1 = 2'd1,
    ST_GOT2 = 2'd2
  } state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one received character: hex digit (any case)
// with its nibble value, or line terminator.
module ascii_hex_decode
  import uart_pkg::*;
(
  input  logic [7:0] i_Char,
  output logic       o_Is_Hex,
  output logic       o_Is_Term,
  output logic [3:0] o_Nibble
);

  always_comb begin
    o_Is_Hex  = 1'b0;
    o_Nibble  = '0;
    o_Is_Term = (i_Char == ASCII_CR) || (i_Char == ASCII_LF);
    if ((i_Char >= ASCII_0) && (i_Char <= ASCII_9)) begin
      o_Is_Hex = 1'b1;
      o_Nibble = 4'(i_Char - ASCII_0);
    end else if ((i_Char >= ASCII_UC_A) && (i_Char <= ASCII_UC_F)) begin
      o_Is_Hex = 1'b1;
      o_Nibble = 4'(i_Char - ASCII_UC_A + 8'd10);
    end else if ((i_Char >= ASCII_LC_A) && (i_Char <= ASCII_LC_F)) begin
      o_Is_Hex = 1'b1;
      o_Nibble = 4'(i_Char - ASCII_LC_A + 8'd10);
    end
  end

endmodule

// File: rtl/uart_hex_parser.sv
// Parses "HH<CR|LF>" ASCII commands from the UART receiver into committed
// bytes, flagging malformed input and inter-character timeouts.
module uart_hex_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_TIMEOUT = 1085000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DV,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_TIMEOUT);

  state_t           r_State, w_State_Next;
  logic [CNT_W-1:0] r_Cnt, w_Cnt_Next;
  logic [3:0]       r_Hi, w_Hi_Next, r_Lo, w_Lo_Next;
  logic [7:0]       r_Byte, w_Byte_Next;
  logic             r_Byte_DV, w_Byte_DV_Next;
  logic             r_Err, w_Err_Next;
  logic [1:0]       r_Err_Code, w_Err_Code_Next;

  logic             w_Is_Hex, w_Is_Term;
  logic [3:0]       w_Nibble;

  ascii_hex_decode u_decode (
    .i_Char    (i_RX_Byte),
    .o_Is_Hex  (w_Is_Hex),
    .o_Is_Term (w_Is_Term),
    .o_Nibble  (w_Nibble)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State    <= ST_IDLE;
      r_Cnt      <= '0;
      r_Hi       <= '0;
      r_Lo       <= '0;
      r_Byte     <= '0;
      r_Byte_DV  <= 1'b0;
      r_Err      <= 1'b0;
      r_Err_Code <= ERR_NONE;
    end else begin
      r_State    <= w_State_Next;
      r_Cnt      <= w_Cnt_Next;
      r_Hi       <= w_Hi_Next;
      r_Lo       <= w_Lo_Next;
      r_Byte     <= w_Byte_Next;
      r_Byte_DV  <= w_Byte_DV_Next;
      r_Err      <= w_Err_Next;
      r_Err_Code <= w_Err_Code_Next;
    end
  end

  always_comb begin
    w_State_Next    = r_State;
    w_Cnt_Next      = r_Cnt;
    w_Hi_Next       = r_Hi;
    w_Lo_Next       = r_Lo;
    w_Byte_Next     = r_Byte;
    w_Byte_DV_Next  = 1'b0;
    w_Err_Next      = 1'b0;
    w_Err_Code_Next = r_Err_Code;

    // A received byte takes priority over a timeout landing on the same cycle.
    if (i_RX_DV) begin
      w_Cnt_Next = '0;
      unique case (r_State)
        ST_IDLE: begin
          if (w_Is_Hex) begin
            w_Hi_Next    = w_Nibble;
            w_State_Next = ST_GOT1;
          end else if (!w_Is_Term && (i_RX_Byte != ASCII_SPACE)) begin
            w_Err_Next      = 1'b1;
            w_Err_Code_Next = ERR_CHAR;
          end
        end
        ST_GOT1: begin
          if (w_Is_Hex) begin
            w_Lo_Next    = w_Nibble;
            w_State_Next = ST_GOT2;
          end else begin
            w_Err_Next      = 1'b1;
            w_Err_Code_Next = w_Is_Term ? ERR_LEN : ERR_CHAR;
            w_State_Next    = ST_IDLE;
          end
        end
        ST_GOT2: begin
          if (w_Is_Term) begin
            w_Byte_Next    = {r_Hi, r_Lo};
            w_Byte_DV_Next = 1'b1;
          end else begin
            w_Err_Next      = 1'b1;
            w_Err_Code_Next = w_Is_Hex ? ERR_LEN : ERR_CHAR;
          end
          w_State_Next = ST_IDLE;
        end
        default: w_State_Next = ST_IDLE;
      endcase
    end else if (r_State != ST_IDLE) begin
      if (r_Cnt == CNT_W'(CLKS_TIMEOUT - 1)) begin
        w_Err_Next      = 1'b1;
        w_Err_Code_Next = ERR_TIMEOUT;
        w_State_Next    = ST_IDLE;
        w_Cnt_Next      = '0;
      end else begin
        w_Cnt_Next = r_Cnt + CNT_W'(1);
      end
    end

    if (w_State_Next == ST_IDLE) begin
      w_Hi_Next = '0;
      w_Lo_Next = '0;
    end
  end

  assign o_Byte     = r_Byte;
  assign o_Byte_DV  = r_Byte_DV;
  assign o_Err      = r_Err;
  assign o_Err_Code = r_Err_Code;
  assign o_Busy     = (r_State != ST_IDLE);

endmodule

// File: tb/tb_uart_hex_parser.sv
// Directed bench for uart_hex_parser: back-to-back character table plus
// hand-written timeout, same-cycle-byte and mid-command reset sequences.
module tb_uart_hex_parser;

  localparam int unsigned T = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [7:0] o_byte;
  logic       o_byte_dv;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  int unsigned n_vec;
  int unsigned n_bad;

  typedef struct {
    logic [7:0] ch;
    logic       dv;
    logic       err;
    logic [1:0] code;
    logic [7:0] byt;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  uart_hex_parser #(.CLKS_TIMEOUT(T)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .o_Byte     (o_byte),
    .o_Byte_DV  (o_byte_dv),
    .o_Err      (o_err),
    .o_Err_Code (o_err_code),
    .o_Busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {3'b000, o_byte_dv, o_err, o_err_code, o_byte, o_busy};
  endfunction

  function automatic logic [15:0] pack(input logic dv, input logic err,
                                       input logic [1:0] code, input logic [7:0] byt,
                                       input logic busy);
    return {3'b000, dv, err, code, byt, busy};
  endfunction

  task automatic add(input logic [7:0] ch, input logic dv, input logic err,
                     input logic [1:0] code, input logic [7:0] byt, input logic busy);
    vec_t v;
    v.ch = ch; v.dv = dv; v.err = err; v.code = code; v.byt = byt; v.busy = busy;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;

    //      ch     dv    err   code  byte   busy
    add(8'h33, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1); // '3'
    add(8'h46, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1); // 'F'
    add(8'h0D, 1'b1, 1'b0, 2'd0, 8'h3F, 1'b0); // CR commit 3F
    add(8'h0A, 1'b0, 1'b0, 2'd0, 8'h3F, 1'b0); // LF ignored
    add(8'h61, 1'b0, 1'b0, 2'd0, 8'h3F, 1'b1); // 'a'
    add(8'h35, 1'b0, 1'b0, 2'd0, 8'h3F, 1'b1); // '5'
    add(8'h0A, 1'b1, 1'b0, 2'd0, 8'hA5, 1'b0); // LF commit A5
    add(8'h47, 1'b0, 1'b1, 2'd1, 8'hA5, 1'b0); // 'G' bad char
    add(8'h37, 1'b0, 1'b0, 2'd1, 8'hA5, 1'b1); // '7'
    add(8'h0D, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0); // CR too short
    add(8'h31, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1); // '1'
    add(8'h32, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1); // '2'
    add(8'h33, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0); // '3' too long
    add(8'h20, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b0); // space ignored
    add(8'h31, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1); // '1'
    add(8'h32, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b1); // '2'
    add(8'h0D, 1'b1, 1'b0, 2'd2, 8'h12, 1'b0); // CR commit 12
    add(8'h62, 1'b0, 1'b0, 2'd2, 8'h12, 1'b1); // 'b'
    add(8'h20, 1'b0, 1'b1, 2'd1, 8'h12, 1'b0); // space inside command
    add(8'h65, 1'b0, 1'b0, 2'd1, 8'h12, 1'b1); // 'e'
    add(8'h44, 1'b0, 1'b0, 2'd1, 8'h12, 1'b1); // 'D'
    add(8'h0D, 1'b1, 1'b0, 2'd1, 8'hED, 1'b0); // CR commit ED
    add(8'h39, 1'b0, 1'b0, 2'd1, 8'hED, 1'b1); // '9'
    add(8'h40, 1'b0, 1'b1, 2'd1, 8'hED, 1'b0); // '@' just below 'A'
    add(8'h46, 1'b0, 1'b0, 2'd1, 8'hED, 1'b1); // 'F'
    add(8'h30, 1'b0, 1'b0, 2'd1, 8'hED, 1'b1); // '0'
    add(8'h3A, 1'b0, 1'b1, 2'd1, 8'hED, 1'b0); // ':' just above '9'
    add(8'h2F, 1'b0, 1'b1, 2'd1, 8'hED, 1'b0); // '/' just below '0'
    add(8'h66, 1'b0, 1'b0, 2'd1, 8'hED, 1'b1); // 'f'
    add(8'h41, 1'b0, 1'b0, 2'd1, 8'hED, 1'b1); // 'A'
    add(8'h0A, 1'b1, 1'b0, 2'd1, 8'hFA, 1'b0); // LF commit FA

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    check("reset", outs(), pack(1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
    rst_n = 1'b1;

    // Table: one character per cycle, back to back
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = vt[0].ch;
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            pack(vt[i].dv, vt[i].err, vt[i].code, vt[i].byt, vt[i].busy));
      if (i + 1 < vt.size()) rx_byte = vt[i + 1].ch;
      else rx_dv = 1'b0;
    end
    @(negedge clk);
    check("after_table", outs(), pack(1'b0, 1'b0, 2'd1, 8'hFA, 1'b0));

    // Timeout: '4' then silence; error shows T+1 cycles after the strobe cycle
    rx_dv   = 1'b1;
    rx_byte = 8'h34;
    @(negedge clk);
    rx_dv = 1'b0;
    for (int k = 1; k <= int'(T) + 1; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("tmo_k%0d", k), {14'd0, o_err, o_busy},
            {14'd0, (k == int'(T) + 1), (k <= int'(T))});
    end
    check("tmo_code", outs(), pack(1'b0, 1'b1, 2'd3, 8'hFA, 1'b0));

    // Byte arriving on the would-be timeout cycle wins
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = 8'h34;
    @(negedge clk);
    rx_dv = 1'b0;
    for (int k = 1; k <= int'(T); k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("race_k%0d", k), {14'd0, o_err, o_busy}, {14'd0, 1'b0, 1'b1});
      if (k == int'(T)) begin
        rx_dv   = 1'b1;
        rx_byte = 8'h30;
      end
    end
    @(negedge clk);
    check("race_got2", outs(), pack(1'b0, 1'b0, 2'd3, 8'hFA, 1'b1));
    rx_byte = 8'h0D;
    @(negedge clk);
    rx_dv = 1'b0;
    check("race_commit", outs(), pack(1'b1, 1'b0, 2'd3, 8'h40, 1'b0));
    @(negedge clk);
    check("race_hold", outs(), pack(1'b0, 1'b0, 2'd3, 8'h40, 1'b0));

    // Reset mid-command, then the next byte starts a fresh command
    rx_dv   = 1'b1;
    rx_byte = 8'h39;
    @(negedge clk);
    rx_dv = 1'b0;
    check("rst_busy", outs(), pack(1'b0, 1'b0, 2'd3, 8'h40, 1'b1));
    #2 rst_n = 1'b0;
    #1 check("rst_async", outs(), pack(1'b0, 1'b0, 2'd0, 8'h00, 1'b0));
    @(negedge clk);
    rst_n   = 1'b1;
    rx_dv   = 1'b1;
    rx_byte = 8'h42;
    @(negedge clk);
    check("rst_B", outs(), pack(1'b0, 1'b0, 2'd0, 8'h00, 1'b1));
    rx_byte = 8'h0D;
    @(negedge clk);
    rx_dv = 1'b0;
    check("rst_B_cr", outs(), pack(1'b0, 1'b1, 2'd2, 8'h00, 1'b0));
    @(negedge clk);
    check("rst_end", outs(), pack(1'b0, 1'b0, 2'd2, 8'h00, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
